// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// Independent write and read FSMs; every output is driven from a flop.
module axi4_lite_slave_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_REGS  = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int unsigned IDXW   = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN   = 32'(4 * NUM_REGS);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;
    logic [31:0] regs [NUM_REGS];

    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    logic        do_wr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] wr_offset;
    logic        wr_in_range;
    logic [IDXW-1:0] wr_idx;

    logic [31:0] rd_offset;
    logic        rd_in_range;
    logic [IDXW-1:0] rd_idx;

    // Protection attributes carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{awprot, arprot};

    // Select the address/data pair that completes a write this cycle,
    // mixing freshly presented and previously captured halves.
    always_comb begin
        do_wr   = 1'b0;
        wr_addr = aw_addr_q;
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        case (w_state)
            W_IDLE: begin
                if (awvalid && awready && wvalid && wready) begin
                    do_wr   = 1'b1;
                    wr_addr = awaddr;
                    wr_data = wdata;
                    wr_strb = wstrb;
                end
            end
            W_WAIT_DATA: begin
                if (wvalid && wready) begin
                    do_wr   = 1'b1;
                    wr_data = wdata;
                    wr_strb = wstrb;
                end
            end
            W_WAIT_ADDR: begin
                if (awvalid && awready) begin
                    do_wr   = 1'b1;
                    wr_addr = awaddr;
                end
            end
            default: ;
        endcase
    end

    // Address decode for both channels, relative to BASE_ADDR.
    always_comb begin
        wr_offset   = wr_addr - BASE_ADDR;
        wr_in_range = wr_offset < SPAN;
        wr_idx      = wr_offset[IDXW+1:2];
        rd_offset   = araddr - BASE_ADDR;
        rd_in_range = rd_offset < SPAN;
        rd_idx      = rd_offset[IDXW+1:2];
    end

    // Write FSM: handshakes, register update and write response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (do_wr && wr_in_range) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (wr_strb[b]) begin
                        regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            if (do_wr) begin
                w_state <= W_RESP;
                awready <= 1'b0;
                wready  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_in_range ? OKAY : SLVERR;
            end else begin
                case (w_state)
                    W_IDLE: begin
                        if (awvalid && awready) begin
                            aw_addr_q <= awaddr;
                            w_state   <= W_WAIT_DATA;
                            awready   <= 1'b0;
                            wready    <= 1'b1;
                        end else if (wvalid && wready) begin
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                            w_state  <= W_WAIT_ADDR;
                            wready   <= 1'b0;
                            awready  <= 1'b1;
                        end else begin
                            awready <= 1'b1;
                            wready  <= 1'b1;
                        end
                    end
                    W_RESP: begin
                        if (bready) begin
                            w_state <= W_IDLE;
                            bvalid  <= 1'b0;
                            awready <= 1'b1;
                            wready  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read FSM: capture data on the AR handshake, hold until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        rdata   <= rd_in_range ? regs[rd_idx] : '0;
                        rresp   <= rd_in_range ? OKAY : SLVERR;
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
